// File: rtl/activation_requant.sv
// activation_requant: captures a packed accumulator vector, then ReLU, rounds,
// shifts and saturates one row per cycle, and publishes the activations with argmax and clip stats.
// Ports:
//   clk, rst_overall (sync, active-high), in_valid/in_data (accumulator vector in),
//   out/out_valid (packed activations), busy, max_idx/max_val (argmax), sat_count, overrun.
module activation_requant #(
  parameter int layer_no  = 0,
  parameter int rows      = 30,
  parameter int columns   = 64,
  parameter int datawidth = 11,
  parameter int shift     = 5,
  parameter int relu_en   = 1,
  localparam int IN_W = 2*datawidth + $clog2(columns),
  localparam int RIW  = $clog2(rows),
  localparam int SCW  = $clog2(rows+1)
) (
  input  logic                          clk,
  input  logic                          rst_overall,
  input  logic                          in_valid,
  input  logic [rows*IN_W-1:0]          in_data,
  output logic [rows*datawidth-1:0]     out,
  output logic                          out_valid,
  output logic                          busy,
  output logic [RIW-1:0]                max_idx,
  output logic signed [datawidth-1:0]   max_val,
  output logic [SCW-1:0]                sat_count,
  output logic                          overrun
);

  if (shift < 0 || shift >= IN_W || rows < 2 || layer_no < 0)
  begin : g_bad_param
    $error("activation_requant: parameter out of range");
  end

  localparam int SH1 = (shift > 0) ? shift - 1 : 0;
  localparam int MAXI = 2**(datawidth-1) - 1;

  // Half-LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [IN_W:0] RND =
    (shift > 0) ? ((IN_W+1)'(1) <<< SH1) : '0;
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(MAXI);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [IN_W-1:0]      buffer [rows];
  logic signed [datawidth-1:0] wout   [rows];
  logic [RIW-1:0]              row_idx;
  logic [RIW-1:0]              widx;
  logic signed [datawidth-1:0] wmax;
  logic [SCW-1:0]              wsat;

  logic                        last;
  logic signed [IN_W-1:0]      x_raw;
  logic signed [IN_W:0]        x_ext;
  logic signed [IN_W:0]        x_rnd;
  logic signed [IN_W:0]        t;
  logic                        clip_hi;
  logic                        clip_lo;
  logic signed [datawidth-1:0] y;
  logic                        better;

  assign last = (row_idx == RIW'(rows-1));

  always_ff @(posedge clk) begin
    if (rst_overall) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // One extra bit keeps rounding of the largest positive input from wrapping.
  always_comb begin
    x_raw = buffer[row_idx];
    x_ext = {x_raw[IN_W-1], x_raw};
    if (relu_en != 0 && x_raw[IN_W-1]) x_ext = '0;
    x_rnd = x_ext + RND;
    t = x_rnd >>> shift;
    clip_hi = (t > MAXV);
    clip_lo = (t < MINV);
    if (clip_hi) y = MAXV[datawidth-1:0];
    else if (clip_lo) y = MINV[datawidth-1:0];
    else y = t[datawidth-1:0];
    // Strictly greater, so ties keep the lowest row.
    better = (row_idx == '0) || (y > wmax);
  end

  always_ff @(posedge clk) begin
    if (rst_overall) begin
      for (int k = 0; k < rows; k++) begin
        buffer[k] <= '0;
        wout[k]   <= '0;
      end
      row_idx   <= '0;
      widx      <= '0;
      wmax      <= '0;
      wsat      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      max_idx   <= '0;
      max_val   <= '0;
      sat_count <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < rows; k++) begin
              buffer[k] <= in_data[(rows-k-1)*IN_W +: IN_W];
            end
            row_idx <= '0;
            widx    <= '0;
            wmax    <= '0;
            wsat    <= '0;
          end
        end
        RUN: begin
          wout[row_idx] <= y;
          if (clip_hi || clip_lo) wsat <= wsat + 1'b1;
          if (better) begin
            wmax <= y;
            widx <= row_idx;
          end
          if (!last) row_idx <= row_idx + 1'b1;
        end
        DONE: begin
          for (int k = 0; k < rows; k++) begin
            out[(rows-k-1)*datawidth +: datawidth] <= wout[k];
          end
          max_idx   <= widx;
          max_val   <= wmax;
          sat_count <= wsat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_requant.sv
// tb_activation_requant: scoreboard bench for activation_requant, rows=4.
// Two instances (ReLU on / off) share stimulus; monitors pop expected results.
module tb_activation_requant;

  localparam int ROWS = 4;
  localparam int DW   = 11;
  localparam int IN_W = 28;
  localparam int OW   = ROWS*DW;

  logic clk = 1'b0;
  logic rst_overall = 1'b1;
  logic in_valid = 1'b0;
  logic [ROWS*IN_W-1:0] in_data = '0;

  logic [OW-1:0] r_out, n_out;
  logic r_ov, n_ov, r_busy, n_busy, r_orun, n_orun;
  logic [1:0] r_idx, n_idx;
  logic [DW-1:0] r_val, n_val;
  logic [2:0] r_sat, n_sat;

  activation_requant #(
    .rows(ROWS), .columns(64), .datawidth(DW), .shift(5), .relu_en(1)
  ) dut_r (
    .clk(clk), .rst_overall(rst_overall),
    .in_valid(in_valid), .in_data(in_data),
    .out(r_out), .out_valid(r_ov), .busy(r_busy),
    .max_idx(r_idx), .max_val(r_val),
    .sat_count(r_sat), .overrun(r_orun)
  );

  activation_requant #(
    .rows(ROWS), .columns(64), .datawidth(DW), .shift(5), .relu_en(0)
  ) dut_n (
    .clk(clk), .rst_overall(rst_overall),
    .in_valid(in_valid), .in_data(in_data),
    .out(n_out), .out_valid(n_ov), .busy(n_busy),
    .max_idx(n_idx), .max_val(n_val),
    .sat_count(n_sat), .overrun(n_orun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] out;
    logic [1:0]    idx;
    logic [DW-1:0] val;
    logic [2:0]    sat;
    int            cyc;
  } exp_t;

  exp_t qr[$];
  exp_t qn[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t mk(int a, int b, int c, int d,
                              int idx, int val, int sat);
    exp_t e;
    e.out = {DW'(a), DW'(b), DW'(c), DW'(d)};
    e.idx = 2'(idx);
    e.val = DW'(val);
    e.sat = 3'(sat);
    e.cyc = 0;
    return e;
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, exp_t e, logic [OW-1:0] o,
                         logic [1:0] i, logic [DW-1:0] v, logic [2:0] s);
    cmp({tag, ".out"}, 64'(o), 64'(e.out));
    cmp({tag, ".max_idx"}, 64'(i), 64'(e.idx));
    cmp({tag, ".max_val"}, 64'(v), 64'(e.val));
    cmp({tag, ".sat_count"}, 64'(s), 64'(e.sat));
    cmp({tag, ".latency"}, 64'(cyc), 64'(e.cyc));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (r_ov) begin
      if (qr.size() == 0) begin
        cmp("relu1.unexpected_out_valid", 64'(r_ov), 64'd0);
      end else begin
        e = qr.pop_front();
        chk_out("relu1", e, r_out, r_idx, r_val, r_sat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (n_ov) begin
      if (qn.size() == 0) begin
        cmp("relu0.unexpected_out_valid", 64'(n_ov), 64'd0);
      end else begin
        e = qn.pop_front();
        chk_out("relu0", e, n_out, n_idx, n_val, n_sat);
      end
    end
  end

  // Called at a negedge; in_valid is sampled on the following posedge.
  task automatic send(int a, int b, int c, int d, bit push,
                      exp_t er, exp_t en);
    in_data = {IN_W'(a), IN_W'(b), IN_W'(c), IN_W'(d)};
    in_valid = 1'b1;
    if (push) begin
      er.cyc = cyc + 6;
      en.cyc = cyc + 6;
      qr.push_back(er);
      qn.push_back(en);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (qr.size() == 0 && qn.size() == 0) break;
      @(negedge clk);
      #1;
    end
    cmp("drain_pending", 64'(qr.size() + qn.size()), 64'd0);
  endtask

  task automatic chk_zero(string tag);
    cmp({tag, ".r_out"}, 64'(r_out), 64'd0);
    cmp({tag, ".n_out"}, 64'(n_out), 64'd0);
    cmp({tag, ".r_max_idx"}, 64'(r_idx), 64'd0);
    cmp({tag, ".r_max_val"}, 64'(r_val), 64'd0);
    cmp({tag, ".n_max_val"}, 64'(n_val), 64'd0);
    cmp({tag, ".r_sat"}, 64'(r_sat), 64'd0);
    cmp({tag, ".n_sat"}, 64'(n_sat), 64'd0);
    cmp({tag, ".r_busy"}, 64'(r_busy), 64'd0);
    cmp({tag, ".r_overrun"}, 64'(r_orun), 64'd0);
    cmp({tag, ".n_overrun"}, 64'(n_orun), 64'd0);
    cmp({tag, ".r_out_valid"}, 64'(r_ov), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_overall = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp("idle.r_busy", 64'(r_busy), 64'd0);
      cmp("idle.n_busy", 64'(n_busy), 64'd0);
    end

    send(100, -100, 1000000, 0, 1'b1,
         mk(3, 0, 1023, 0, 2, 1023, 1),
         mk(3, -3, 1023, 0, 2, 1023, 1));
    cmp("run.r_busy", 64'(r_busy), 64'd1);
    repeat (5) @(negedge clk);
    send(-100, -1000000, 15, 16, 1'b1,
         mk(0, 0, 0, 1, 3, 1, 0),
         mk(-3, -1024, 0, 1, 3, 1, 1));
    repeat (5) @(negedge clk);
    send(64, 64, 32, -32, 1'b1,
         mk(2, 2, 1, 0, 0, 2, 0),
         mk(2, 2, 1, -1, 0, 2, 0));
    repeat (5) @(negedge clk);
    send(32751, 32752, -32784, -32785, 1'b1,
         mk(1023, 1023, 0, 0, 0, 1023, 1),
         mk(1023, 1023, -1024, -1024, 0, 1023, 2));
    repeat (5) @(negedge clk);
    send(134217727, -134217728, 0, 31, 1'b1,
         mk(1023, 0, 0, 1, 0, 1023, 1),
         mk(1023, -1024, 0, 1, 0, 1023, 2));
    drain();
    cmp("pre_overrun.r", 64'(r_orun), 64'd0);

    send(64, 64, 32, -32, 1'b1,
         mk(2, 2, 1, 0, 0, 2, 0),
         mk(2, 2, 1, -1, 0, 2, 0));
    @(negedge clk);
    in_data = {IN_W'(5000), IN_W'(6000), IN_W'(7000), IN_W'(8000)};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    cmp("overrun.r", 64'(r_orun), 64'd1);
    cmp("overrun.n", 64'(n_orun), 64'd1);

    send(32751, 32752, -32784, -32785, 1'b0,
         mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_overall = 1'b1;
    @(negedge clk);
    rst_overall = 1'b0;
    repeat (8) @(negedge clk);
    chk_zero("mid_reset");

    send(-100, -1000000, 15, 16, 1'b1,
         mk(0, 0, 0, 1, 3, 1, 0),
         mk(-3, -1024, 0, 1, 3, 1, 1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/activation_requant.md
# activation_requant

Downstream stage of a systolic MAC layer. Captures the layer's packed wide accumulator vector on its `done` pulse and applies optional ReLU, round-half-up arithmetic right shift and saturation to `datawidth` bits, one row per cycle. Emits a packed vector in the exact format of the next layer's `values` input, plus argmax and saturation statistics for the final layer's classification readout.

## Interface
Parameters:
- `layer_no`, 0, layer index; informational only.
- `rows`, 30, number of neurons per input vector; equals the upstream layer's rows and the next layer's columns.
- `columns`, 64, upstream layer's column count; sets input word width.
- `datawidth`, 11, output word width; upstream product width is 2*datawidth.
- `shift`, 5, right-shift amount applied to each accumulator; 0 to IN_W-1.
- `relu_en`, 1, 1 = negative inputs forced to 0 before shifting.
- Derived: IN_W = 2*datawidth + $clog2(columns) (28 at defaults).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_overall`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  upstream layer `done`, a one-cycle pulse.
- `in_data`  in  rows*IN_W  signed packed accumulators; row k at bits [(rows-k-1)*IN_W +: IN_W].
- `out`  out  rows*datawidth  signed packed activations; row k at [(rows-k-1)*datawidth +: datawidth].
- `out_valid`  out  1  one-cycle pulse; `out` and statistics are new.
- `busy`  out  1  high while a vector is being processed.
- `max_idx`  out  $clog2(rows)  row index of the largest output value.
- `max_val`  out  datawidth  signed largest output value.
- `sat_count`  out  $clog2(rows+1)  rows clipped in the last vector.
- `overrun`  out  1  sticky; `in_valid` arrived while busy.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - When `in_valid` is high, register all of `in_data` into an internal buffer.
  - Set row_idx = 0, clear the working argmax and sat counters, go to RUN.
- RUN: each cycle process buffer row row_idx.
  - ReLU: if relu_en and x < 0, then x = 0.
  - Rounding: if shift > 0, t = (x + 2^(shift-1)) >>> shift, computed in IN_W+1 bits (no wrap); if shift == 0, t = x.
  - Saturation: clip t to [-2^(datawidth-1), 2^(datawidth-1)-1]. If clipped, increment the working sat counter.
  - Write the result to the working output buffer at row row_idx.
  - Argmax: row 0 initialises the working max. A later row replaces it only if strictly greater, so ties keep the lowest index.
  - At row_idx == rows-1, go to DONE; otherwise increment row_idx.
- DONE:
  - Copy the working buffer to `out`, the working argmax to `max_idx`/`max_val`, and the working sat counter to `sat_count`.
  - Pulse `out_valid`, return to IDLE.
- `out`, `max_idx`, `max_val` and `sat_count` hold their values until the next DONE.
- `in_valid` in RUN or DONE: ignored (the vector is dropped), `overrun` is set to 1, and the current vector completes unaffected.
- `rst_overall`: all registers cleared next edge, state IDLE, partial vector discarded. Reset has priority over a simultaneous `in_valid`.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `busy` = 0, `max_idx` = 0, `max_val` = 0, `sat_count` = 0, `overrun` = 0.
- `in_valid` sampled high at edge E0 (state IDLE).
- RUN processes row k at edge E0+1+k.
- DONE at edge E0+rows+1 updates the outputs; `out_valid` is high for the following cycle only.
- Latency from `in_valid` to `out_valid` is rows+1 cycles; throughput is one vector per rows+2 cycles.
- `busy` is high from after E0 until after E0+rows+1; `busy` equals state != IDLE.
- A new `in_valid` is accepted in the same cycle `out_valid` is high.
- No combinational path from any input to any output.

## Test plan
Bench settings for all scenarios: rows=4, columns=64, datawidth=11, shift=5.
- Reset then idle: all outputs 0, `busy` stays 0, `out_valid` never asserts.
- relu_en=1, rows = {100, -100, 1000000, 0}:
  - Expected `out` = {3, 0, 1023, 0}, `sat_count` = 1, `max_idx` = 2, `max_val` = 1023.
  - `out_valid` exactly 5 cycles after `in_valid`.
- relu_en=0, rows = {-100, -1000000, 15, 16}:
  - Expected `out` = {-3, -1024, 0, 1}, `sat_count` = 1, `max_idx` = 3.
- Ties, rows = {64, 64, 32, -32} with relu_en=1:
  - Expected `out` = {2, 2, 1, 0}, `max_idx` = 0, `max_val` = 2.
- Second `in_valid` 2 cycles after the first:
  - First result correct, the second vector produces no `out_valid`, `overrun` = 1 until reset.
- `rst_overall` asserted during RUN at row 2:
  - No `out_valid`, outputs 0.
  - A fresh `in_valid` after reset produces the correct result with normal latency.
